// File: rtl/upsample_ctrl_pkg.sv
// upsample_ctrl_pkg: shared widths, defaults and FSM encoding for the upsample controller
package upsample_ctrl_pkg;
    localparam int ADDR_WIDTH_DEF = 20;
    localparam int CNT_WIDTH_DEF = 32;
    localparam int DIM_WIDTH = 10;
    localparam int UPSAMPLE_SHIFT = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/upsample_ctrl_addr_gen.sv
// upsample_addr_gen: registered feature-buffer read address, base plus running offset
module upsample_addr_gen
    import upsample_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] addr
);
    logic [ADDR_WIDTH-1:0] off;
    always_ff @(posedge system_clk) begin
        if (!rst_n || clr) begin
            off  <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= base + off;
            off  <= off + ADDR_WIDTH'(1);
        end
    end
endmodule

// File: rtl/upsample_ctrl.sv
// upsample_ctrl: layer sequencer issuing feature reads and waiting for 4x upsampled output
module upsample_ctrl
    import upsample_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_WIDTH-1:0]  col_size,
    input  logic [DIM_WIDTH-1:0]  row_size,
    input  logic [DIM_WIDTH-1:0]  channel_num,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  feature_ready,
    input  logic                  upsample_feature_valid,
    input  logic                  upsample_buffer_empty,
    output logic                  busy,
    output logic                  done
);
    state_t                state;
    logic                  calc, armed, issue, active;
    logic [DIM_WIDTH-1:0]  col_r, row_r, ch_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CNT_WIDTH-1:0]  prod, total_in, total_out, in_cnt, out_cnt;

    assign prod   = CNT_WIDTH'(col_r) * CNT_WIDTH'(row_r) * CNT_WIDTH'(ch_r);
    assign issue  = state == RUN && feature_ready && in_cnt < total_in;
    assign active = state == RUN || state == DRAIN;

    upsample_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .system_clk(system_clk),
        .rst_n(rst_n),
        .base(base_r),
        .inc(issue),
        .clr(abort || state == IDLE),
        .addr(rd_addr)
    );

    // Launch takes three IDLE edges: capture config, register product, then branch on it.
    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            calc      <= 1'b0;
            armed     <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            col_r     <= '0;
            row_r     <= '0;
            ch_r      <= '0;
            base_r    <= '0;
            total_in  <= '0;
            total_out <= '0;
        end else if (abort) begin
            state   <= IDLE;
            calc    <= 1'b0;
            armed   <= 1'b0;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            rd_en <= issue;
            done  <= 1'b0;
            calc  <= 1'b0;
            armed <= 1'b0;
            if (issue) in_cnt <= in_cnt + CNT_WIDTH'(1);
            if (active && upsample_feature_valid) out_cnt <= out_cnt + CNT_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (armed) begin
                        state <= total_in == '0 ? DONE : RUN;
                        busy  <= total_in != '0;
                        done  <= total_in == '0;
                    end else if (calc) begin
                        total_in  <= prod;
                        total_out <= prod << UPSAMPLE_SHIFT;
                        armed     <= 1'b1;
                    end else if (start) begin
                        col_r   <= col_size;
                        row_r   <= row_size;
                        ch_r    <= channel_num;
                        base_r  <= base_addr;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        calc    <= 1'b1;
                    end
                end
                RUN: if (in_cnt == total_in) state <= DRAIN;
                DRAIN: begin
                    if (out_cnt == total_out && upsample_buffer_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upsample_ctrl.sv
// tb_upsample_ctrl: scoreboard bench with an upsample-side emulator and randomized layers
module tb_upsample_ctrl;
    localparam int AW = 20;
    localparam int unsigned MASK = (1 << AW) - 1;

    logic          system_clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [9:0]    col_size = 0, row_size = 0, channel_num = 0;
    logic [AW-1:0] base_addr = 0;
    logic          rd_en, busy, done;
    logic [AW-1:0] rd_addr;
    logic          feature_ready = 1, upsample_feature_valid = 0, upsample_buffer_empty = 1;

    int n_checks = 0, n_fail = 0;
    int unsigned addr_q[$];
    int done_q[$];
    int cyc = 0, layer_reads = 0, done_cnt = 0, last_done_cyc = 0, start_cyc = 0, pending = 0, fr_mode = 0;
    bit hold_beats = 0, glitch = 0, busy_seen = 0;

    upsample_ctrl dut (
        .system_clk(system_clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .col_size(col_size),
        .row_size(row_size),
        .channel_num(channel_num),
        .base_addr(base_addr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .feature_ready(feature_ready),
        .upsample_feature_valid(upsample_feature_valid),
        .upsample_buffer_empty(upsample_buffer_empty),
        .busy(busy),
        .done(done)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor and upsample emulator: sample after each edge, then drive the next cycle's inputs.
    initial forever begin
        @(posedge system_clk);
        #1;
        cyc++;
        if (!rst_n || abort) pending = 0;
        if (busy) busy_seen = 1;
        if (rd_en) begin
            check("rd_en_after_not_ready", feature_ready, 1);
            layer_reads++;
            pending += 4;
            check("read_expected", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) check("rd_addr", rd_addr, addr_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("done_busy", busy, 0);
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) check("done_reads", layer_reads, done_q.pop_front());
        end
        feature_ready = fr_mode == 0 ? 1'b1 : fr_mode == 1 ? ((cyc / 3) % 2 == 0) : ($urandom_range(3) != 0);
        upsample_feature_valid = glitch || (pending > 0 && !hold_beats && $urandom_range(1) == 1);
        if (upsample_feature_valid && pending > 0) pending--;
        upsample_buffer_empty = pending == 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic launch(int c, int r, int ch, int unsigned b);
        @(negedge system_clk);
        col_size = 10'(c);
        row_size = 10'(r);
        channel_num = 10'(ch);
        base_addr = AW'(b);
        start = 1;
        for (int i = 0; i < c * r * ch; i++) addr_q.push_back((b + i) & MASK);
        done_q.push_back(c * r * ch);
        layer_reads = 0;
        start_cyc = cyc + 1;
        @(negedge system_clk);
        start = 0;
    endtask

    task automatic wait_done(int limit);
        for (int i = 0; i < limit && done_q.size() > 0; i++) @(negedge system_clk);
        check("layer_done_timeout", done_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        @(negedge system_clk);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge system_clk);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1;
        repeat (2) @(negedge system_clk);

        fr_mode = 0;
        d0 = done_cnt;
        launch(4, 2, 1, 'h100);
        wait_done(2000);
        check("basic_done_count", done_cnt - d0, 1);

        fr_mode = 1;
        launch(4, 2, 1, 'h100);
        wait_done(2000);

        fr_mode = 0;
        launch(4, 1, 1, 'hFFFFE);
        wait_done(2000);

        busy_seen = 0;
        launch(0, 5, 3, 'h40);
        wait_done(100);
        check("zero_done_latency", last_done_cyc - start_cyc, 2);
        check("zero_busy_seen", busy_seen, 0);

        launch(4, 2, 1, 'h300);
        for (int i = 0; i < 200 && layer_reads < 3; i++) @(negedge system_clk);
        abort = 1;
        d0 = done_cnt;
        @(negedge system_clk);
        abort = 0;
        check("abort_rd_en", rd_en, 0);
        check("abort_busy", busy, 0);
        addr_q.delete();
        done_q.delete();
        repeat (6) @(negedge system_clk);
        check("abort_reads", layer_reads, 3);
        check("abort_no_done", done_cnt, d0);
        check("abort_idle_rd_en", rd_en, 0);
        launch(2, 1, 1, 'h10);
        wait_done(2000);

        fr_mode = 2;
        hold_beats = 1;
        launch(4, 2, 1, 'h200);
        repeat (4) @(negedge system_clk);
        col_size = 1; row_size = 1; channel_num = 1; base_addr = 0; start = 1;
        @(negedge system_clk);
        start = 0;
        for (int i = 0; i < 300 && layer_reads < 8; i++) @(negedge system_clk);
        repeat (3) @(negedge system_clk);
        check("drain_reads", layer_reads, 8);
        check("drain_busy", busy, 1);
        d0 = done_cnt;
        rst_n = 0;
        @(negedge system_clk);
        rst_n = 1;
        check("midreset_rd_en", rd_en, 0);
        check("midreset_rd_addr", rd_addr, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        addr_q.delete();
        done_q.delete();
        hold_beats = 0;
        repeat (8) @(negedge system_clk);
        check("midreset_no_done", done_cnt, d0);

        for (int k = 0; k < 8; k++) begin
            glitch = 1;
            @(negedge system_clk);
            glitch = 0;
            launch($urandom_range(4), $urandom_range(3, 1), $urandom_range(2, 1), $urandom & MASK);
            wait_done(3000);
        end

        repeat (5) @(negedge system_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
